motion_chase_indicator: RTL
===========================

# motion_chase_indicator

Parametrised seven-segment motion indicator. It takes the 3-bit motion mode from the bot motor controller and animates a single digit: a rotating chase for turns, a blink for forward and reverse, and a steady bar for stop. Rate dividers are derived from clock-frequency parameters, so the same block serves hardware and simulation. Its 5-bit code output feeds the existing seven-segment digit mux; the one-hot output is for debug LEDs.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- SLOW_HZ, 5, chase step rate for 1x turns
- FAST_HZ, 10, chase step rate for 2x turns
- BLINK_HZ, 2, toggle rate for forward/reverse
- SIMULATE, 0, when 1 the divisors are forced to SLOW=6, FAST=3, BLINK=10 cycles
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- motion_mode  input  3  000 STOP, 001 RIGHT_1x, 010 RIGHT_2x, 011 LEFT_1x, 100 LEFT_2x, 101 FORWARD, 110 REVERSE, 111 illegal
- seg_code  output  5  digit-mux code: a..g = 16..22, blank = 23
- seg_onehot  output  8  bit0..bit6 = segments a..g, bit7 = blank; exactly one bit set
- illegal_mode  output  1  registered flag, high while motion_mode == 111

## Operation
- Divisors:
  - DIV_x = CLK_HZ / x_HZ (integer), unless SIMULATE = 1.
  - A single counter cnt, width clog2(max DIV), has its terminal count selected by the current mode's divisor: DIV − 1.
  - tick = (cnt == DIV − 1). On tick, cnt returns to 0.
- Registers:
  - mode_q holds the accepted mode.
  - state is one of SA, SB, SC, SD, SE, SF, SG, BLANK.
  - Outputs are decoded from state and are glitch-free: state is a register, and the decode is a fixed one-hot/code map.
- Mode change: when motion_mode ≠ mode_q at a rising edge:
  - mode_q <= motion_mode
  - cnt <= 0
  - state <= entry(motion_mode)
  - Mode change has priority over tick in the same cycle.
- Entry states:
  - STOP → SG
  - RIGHT_x → SA
  - LEFT_x → SA
  - FORWARD → SA
  - REVERSE → SD
  - illegal → BLANK
- Transitions on tick, when no mode change:
  - STOP: stay in SG. Counter runs with the SLOW divisor; tick has no effect.
  - RIGHT_1x (SLOW divisor) / RIGHT_2x (FAST divisor): SA→SB→SC→SD→SE→SF→SA.
  - LEFT_1x (SLOW) / LEFT_2x (FAST): SA→SF→SE→SD→SC→SB→SA.
  - FORWARD (BLINK divisor): SA↔BLANK.
  - REVERSE (BLINK divisor): SD↔BLANK.
  - illegal: stay in BLANK.
- Stray states: SG or BLANK reached in a chase mode, or any state not valid for the current mode, goes to entry(mode_q) on the next tick.
- illegal_mode <= (motion_mode == 3'b111) every cycle.

## Timing
- Reset values:
  - state = BLANK, so seg_code = 23 and seg_onehot = 8'h80
  - mode_q = 3'b111
  - cnt = 0
  - illegal_mode = 0
- First edge after reset release with a legal mode: treated as a mode change, so the entry state appears after that edge.
- If 111 is held through reset: no change is detected. Output stays BLANK, and illegal_mode rises one edge later.
- Latency:
  - Mode change to new output: 1 cycle.
  - First chase step or blink toggle: DIV cycles after the entry edge.
  - Subsequent steps: every DIV cycles.
- Mode glitches:
  - A change lasting one cycle is accepted. Returning to the old mode counts as another change and restarts at entry.
  - Toggling between two modes every cycle produces only entry states.
- Reset asserted mid-chase: outputs go to BLANK asynchronously, without waiting for clk.

## Test plan
- Reset, then hold RIGHT_1x with SIMULATE=1 → seg_code 16 one cycle after release, then 17, 18, 19, 20, 21, 16 at 6-cycle intervals.
- LEFT_2x with SIMULATE=1 → 16, 21, 20, 19, 18, 17, 16 at 3-cycle intervals; seg_onehot always one-hot.
- FORWARD for 40 cycles, then REVERSE → 16/23 toggling every 10 cycles, then 19 on the cycle after the switch and 23 exactly 10 cycles later.
- RIGHT_1x at position SC, then change to RIGHT_2x in the same cycle as a slow tick → next output 16 (mode change wins, restart), then 17 after 3 cycles.
- Drive 111 for 5 cycles, then STOP → seg_code 23 with illegal_mode = 1 from the cycle after 111 appears; then seg_code 22 and illegal_mode = 0 one cycle after STOP; 22 stays steady for 50 cycles.
- Assert reset asynchronously, between clock edges, mid-chase → seg_code 23 and seg_onehot 8'h80 before the next clk edge; cnt restarts from 0 after release.

Source files
------------

// File: rtl/motion_chase_indicator_if.sv
// Motion indicator bus: the mode input from the motor controller and the
// digit/debug outputs toward the seven-segment mux.
//   motion_mode  : 3-bit motion mode (master drives)
//   seg_code     : 5-bit digit-mux code, a..g = 16..22, blank = 23
//   seg_onehot   : 8-bit one-hot segment select, bit7 = blank
//   illegal_mode : registered flag, high while motion_mode == 3'b111
interface motion_chase_indicator_if;
  logic [2:0] motion_mode;
  logic [4:0] seg_code;
  logic [7:0] seg_onehot;
  logic       illegal_mode;

  modport master (
    output motion_mode,
    input  seg_code,
    input  seg_onehot,
    input  illegal_mode
  );

  modport slave (
    input  motion_mode,
    output seg_code,
    output seg_onehot,
    output illegal_mode
  );
endinterface

// File: rtl/motion_chase_indicator.sv
// Seven-segment motion indicator. Animates one digit from the motor
// controller's motion mode: rotating chase for turns, blink for forward and
// reverse, steady bar (segment g) for stop, blank for the illegal code.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; forces BLANK immediately
//   bus   : slave side of motion_chase_indicator_if (mode in, codes out)
//
// state | meaning
// ------+--------------------------------------------
// SA    | segment a lit (chase start, forward blink on)
// SB    | segment b lit
// SC    | segment c lit
// SD    | segment d lit (reverse blink on)
// SE    | segment e lit
// SF    | segment f lit
// SG    | segment g lit (stop bar)
// BLANK | nothing lit (blink off, illegal mode, reset)
module motion_chase_indicator #(
  parameter int CLK_HZ   = 100_000_000,
  parameter int SLOW_HZ  = 5,
  parameter int FAST_HZ  = 10,
  parameter int BLINK_HZ = 2,
  parameter int SIMULATE = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  motion_chase_indicator_if.slave   bus
);

  localparam int DIV_SLOW  = (SIMULATE == 1) ? 6  : CLK_HZ / SLOW_HZ;
  localparam int DIV_FAST  = (SIMULATE == 1) ? 3  : CLK_HZ / FAST_HZ;
  localparam int DIV_BLINK = (SIMULATE == 1) ? 10 : CLK_HZ / BLINK_HZ;

  localparam int DIV_MAX_SF = (DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST;
  localparam int DIV_MAX    = (DIV_MAX_SF > DIV_BLINK) ? DIV_MAX_SF : DIV_BLINK;
  localparam int CNT_W      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;

  localparam logic [CNT_W-1:0] TC_SLOW  = CNT_W'(DIV_SLOW - 1);
  localparam logic [CNT_W-1:0] TC_FAST  = CNT_W'(DIV_FAST - 1);
  localparam logic [CNT_W-1:0] TC_BLINK = CNT_W'(DIV_BLINK - 1);

  localparam logic [2:0] M_STOP    = 3'b000;
  localparam logic [2:0] M_RIGHT1  = 3'b001;
  localparam logic [2:0] M_RIGHT2  = 3'b010;
  localparam logic [2:0] M_LEFT1   = 3'b011;
  localparam logic [2:0] M_LEFT2   = 3'b100;
  localparam logic [2:0] M_FORWARD = 3'b101;
  localparam logic [2:0] M_REVERSE = 3'b110;
  localparam logic [2:0] M_ILLEGAL = 3'b111;

  // Encoding is chosen so the segment index equals the state value; the
  // output maps below rely on that.
  typedef enum logic [2:0] {
    SA    = 3'd0,
    SB    = 3'd1,
    SC    = 3'd2,
    SD    = 3'd3,
    SE    = 3'd4,
    SF    = 3'd5,
    SG    = 3'd6,
    BLANK = 3'd7
  } state_t;

  state_t           state;
  logic [2:0]       mode_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] tc;
  logic             tick;
  logic             illegal_q;

  function automatic state_t entry_state(input logic [2:0] m);
    case (m)
      M_STOP:                               entry_state = SG;
      M_RIGHT1, M_RIGHT2, M_LEFT1, M_LEFT2: entry_state = SA;
      M_FORWARD:                            entry_state = SA;
      M_REVERSE:                            entry_state = SD;
      default:                              entry_state = BLANK;
    endcase
  endfunction

  // Next state on a tick. Anything not part of the current mode's pattern
  // falls back to the mode's entry state.
  function automatic state_t advance(input state_t s, input logic [2:0] m);
    advance = entry_state(m);
    case (m)
      M_RIGHT1, M_RIGHT2: begin
        case (s)
          SA:      advance = SB;
          SB:      advance = SC;
          SC:      advance = SD;
          SD:      advance = SE;
          SE:      advance = SF;
          SF:      advance = SA;
          default: advance = SA;
        endcase
      end
      M_LEFT1, M_LEFT2: begin
        case (s)
          SA:      advance = SF;
          SF:      advance = SE;
          SE:      advance = SD;
          SD:      advance = SC;
          SC:      advance = SB;
          SB:      advance = SA;
          default: advance = SA;
        endcase
      end
      M_FORWARD: advance = (s == SA) ? BLANK : SA;
      M_REVERSE: advance = (s == SD) ? BLANK : SD;
      M_STOP:    advance = SG;
      default:   advance = BLANK;
    endcase
  endfunction

  // STOP and the illegal code have no visible tick effect but still run
  // the counter on the slow divisor.
  always_comb begin
    tc = TC_SLOW;
    case (mode_q)
      M_RIGHT2, M_LEFT2:    tc = TC_FAST;
      M_FORWARD, M_REVERSE: tc = TC_BLINK;
      default:              tc = TC_SLOW;
    endcase
  end

  assign tick = (cnt == tc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= BLANK;
      mode_q    <= M_ILLEGAL;
      cnt       <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (bus.motion_mode == M_ILLEGAL);
      if (bus.motion_mode != mode_q) begin
        // Mode change beats a coincident tick and restarts the animation.
        mode_q <= bus.motion_mode;
        cnt    <= '0;
        state  <= entry_state(bus.motion_mode);
      end else if (tick) begin
        cnt   <= '0;
        state <= advance(state, mode_q);
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // Pure decode of the state register, so the outputs cannot glitch.
  assign bus.seg_code     = {2'b10, state};
  assign bus.seg_onehot   = 8'b0000_0001 << state;
  assign bus.illegal_mode = illegal_q;

endmodule
